// File: rtl/fxp2f32_pkg.sv
// Shared constants and helpers for the fixed-point to float32 scheduler.
package fxp2f32_pkg;

   localparam int unsigned EXP_BIAS       = 127;
   localparam int unsigned EXP_MAX_FINITE = 254;
   localparam logic [31:0] FLOAT_ZERO     = 32'h0000_0000;

   // Width of a channel index for n requesters (at least one bit).
   function automatic int unsigned ch_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/comb_FixedPointToFloat32.sv
// Combinational signed fixed-point to IEEE-754 single converter.
module comb_FixedPointToFloat32
   import fxp2f32_pkg::*;
#(
   parameter int unsigned WII   = 8,
   parameter int unsigned WIF   = 8,
   parameter int unsigned ROOF  = 1,
   parameter int unsigned ROUND = 1
) (
   input  logic [WII+WIF-1:0] in_fxp,
   output logic [31:0]        out_f32,
   output logic               upflow,
   output logic               downflow
);

   localparam int unsigned W  = WII + WIF;
   localparam int unsigned LW = $clog2(W) + 1;

   logic                 neg;
   logic [W-1:0]         mag;
   logic [LW-1:0]        lead;
   logic [22:0]          tail;
   logic signed [31:0]   exp_s;
   logic                 unused_round;

   // Tail is always truncated; ROUND is kept so existing instantiations elaborate unchanged.
   assign unused_round = (ROUND != 0);

   // Sign-magnitude split, leading-one search, normalisation and range clamp.
   always_comb begin
      neg  = in_fxp[W-1];
      mag  = neg ? W'(-in_fxp) : in_fxp;
      lead = '0;
      for (int i = 0; i < W; i++) begin
         if (mag[i]) lead = LW'(i);
      end
      // Shift the leading one to the top, then keep the 23 bits just below it.
      tail  = 23'(({mag, 23'b0} << (LW'(W - 1) - lead)) >> (W - 1));
      exp_s = 32'(lead) - 32'(WIF) + 32'(EXP_BIAS);

      out_f32  = FLOAT_ZERO;
      upflow   = 1'b0;
      downflow = 1'b0;
      if (mag != '0) begin
         if (exp_s >= 32'sd255) begin
            out_f32  = {neg, 8'(EXP_MAX_FINITE), (ROOF != 0) ? 23'h7F_FFFF : tail};
            upflow   = !neg;
            downflow = neg;
         end else if (exp_s >= 32'sd1) begin
            out_f32 = {neg, exp_s[7:0], tail};
         end
      end
   end

endmodule

// File: rtl/fxp2f32_rr_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, with wrap.
module rr_arbiter #(
   parameter int unsigned NCH = 4,
   parameter int unsigned CHW = 2
) (
   input  logic [NCH-1:0] req,
   input  logic [CHW-1:0] ptr,
   output logic [NCH-1:0] gnt,
   output logic [CHW-1:0] idx,
   output logic           any
);

   logic [CHW-1:0] cand;

   // Scan from farthest to nearest so the nearest requester wins.
   always_comb begin
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         cand = CHW'((32'(ptr) + 32'(k)) % NCH);
         if (req[cand]) begin
            idx = cand;
            any = 1'b1;
         end
      end
      gnt      = '0;
      gnt[idx] = any;
   end

endmodule

// File: rtl/fxp2f32_rr_scheduler.sv
// Round-robin sharing of one fixed-point to float32 converter across NCH streams.
module fxp2f32_rr_scheduler
   import fxp2f32_pkg::*;
#(
   parameter int unsigned NCH   = 4,
   parameter int unsigned WII   = 8,
   parameter int unsigned WIF   = 8,
   parameter int unsigned ROOF  = 1,
   parameter int unsigned ROUND = 1,
   parameter int unsigned CW    = 16
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic [NCH-1:0]             in_valid,
   output logic [NCH-1:0]             in_ready,
   input  logic [NCH*(WII+WIF)-1:0]   in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(NCH)-1:0]     out_ch,
   output logic [31:0]                out_float,
   output logic                       out_upflow,
   output logic                       out_downflow,
   input  logic                       cnt_clr,
   output logic [NCH*CW-1:0]          ovf_cnt
);

   localparam int unsigned W   = WII + WIF;
   localparam int unsigned CHW = ch_w(NCH);

   logic           s1_valid;
   logic [W-1:0]   s1_data;
   logic [CHW-1:0] s1_ch;
   logic [CHW-1:0] rr_ptr;
   logic [CW-1:0]  cnt_q [NCH];

   logic           adv_out_c;
   logic           adv_s1_c;
   logic           accept_c;
   logic [NCH-1:0] gnt_c;
   logic [CHW-1:0] gidx_c;
   logic           gany_c;
   logic [W-1:0]   sel_data_c;
   logic [31:0]    conv_f32_c;
   logic           conv_up_c;
   logic           conv_dn_c;

   assign adv_out_c  = !out_valid || out_ready;
   assign adv_s1_c   = !s1_valid || adv_out_c;
   assign accept_c   = rstn && adv_s1_c && gany_c;
   assign in_ready   = (rstn && adv_s1_c) ? gnt_c : '0;
   assign sel_data_c = in_data[32'(gidx_c) * W +: W];

   rr_arbiter #(.NCH(NCH), .CHW(CHW)) u_arb (
      .req (in_valid),
      .ptr (rr_ptr),
      .gnt (gnt_c),
      .idx (gidx_c),
      .any (gany_c)
   );

   comb_FixedPointToFloat32 #(.WII(WII), .WIF(WIF), .ROOF(ROOF), .ROUND(ROUND)) u_conv (
      .in_fxp   (s1_data),
      .out_f32  (conv_f32_c),
      .upflow   (conv_up_c),
      .downflow (conv_dn_c)
   );

   // Two-stage pipeline (S1 = accepted word, OUT = converted result) and rr pointer.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1_valid     <= 1'b0;
         s1_data      <= '0;
         s1_ch        <= '0;
         out_valid    <= 1'b0;
         out_ch       <= '0;
         out_float    <= FLOAT_ZERO;
         out_upflow   <= 1'b0;
         out_downflow <= 1'b0;
         rr_ptr       <= '0;
      end else begin
         if (adv_s1_c) begin
            s1_valid <= gany_c;
            s1_data  <= sel_data_c;
            s1_ch    <= gidx_c;
         end
         if (adv_out_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_ch       <= s1_ch;
               out_float    <= conv_f32_c;
               out_upflow   <= conv_up_c;
               out_downflow <= conv_dn_c;
            end
         end
         if (accept_c) begin
            rr_ptr <= (32'(gidx_c) == NCH - 1) ? '0 : gidx_c + CHW'(1);
         end
      end
   end

   // Per-channel saturating overflow counters; clear wins over increment.
   always_ff @(posedge clk) begin
      if (!rstn || cnt_clr) begin
         for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      end else if (out_valid && out_ready && (out_upflow || out_downflow)
                   && (cnt_q[out_ch] != '1)) begin
         cnt_q[out_ch] <= cnt_q[out_ch] + CW'(1);
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_cnt
      assign ovf_cnt[i*CW +: CW] = cnt_q[i];
   end

endmodule
